// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port unified memory between instruction fetch (IF) and the
// MEM-stage load/store unit (DM). One access is in flight at a time; each is
// carried over a req/ack memory handshake with variable latency.
//
// DM normally wins arbitration. After STARVE_MAX consecutive DM grants taken
// while IF was waiting, IF is forced through. A BUSY phase that sees no
// mem_ack_i for TIMEOUT cycles is aborted: the requester still gets its ack,
// with zero read data and err_o raised in the same cycle.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   if_req_i, if_addr_i      IF read request (level) and address
//   if_rdata_o, if_ack_o     IF read data, valid with the one-cycle ack pulse
//   dm_req_i, dm_we_i        DM request (level), write enable (1 = store)
//   dm_addr_i, dm_wdata_i    DM address and store data
//   dm_rdata_o, dm_ack_o     DM load data, valid with the one-cycle ack pulse
//   mem_req_o, mem_we_o      memory request / write strobe
//   mem_addr_o, mem_wdata_o  memory address / write data
//   mem_rdata_i, mem_ack_i   memory read data, valid with mem_ack_i
//   err_o                    timeout pulse, coincident with the aborted ack
//   stall_o                  combinational pipeline stall
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              err_o,
  output logic              stall_o
);

  localparam int TO_W = $clog2(TIMEOUT) + 1;
  localparam logic [3:0]      STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_IF = 2'd1,
    S_BUSY_DM = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              dm_ack_q, dm_ack_d;
  logic              err_q, err_d;

  logic              if_forced;
  logic              done_ok;
  logic              done_to;
  logic [DATA_W-1:0] resp_data;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    to_cnt_d     = to_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    // Ack and error are single-cycle pulses: they only live during RESP.
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    err_d        = 1'b0;

    if_forced = (starve_cnt_q == STARVE_LIM) && if_req_i;
    done_ok   = mem_ack_i;
    done_to   = !mem_ack_i && (to_cnt_q == TO_LAST);
    resp_data = done_ok ? mem_rdata_i : '0;

    case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        if (dm_req_i && !if_forced) begin
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          state_d     = S_BUSY_DM;
          // Count DM grants that made a waiting IF step aside; saturate.
          if (if_req_i) begin
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? STARVE_LIM
                                                        : starve_cnt_q + 4'd1;
          end else begin
            starve_cnt_d = '0;
          end
        end else if (if_req_i) begin
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr_i;
          mem_wdata_d  = '0;
          state_d      = S_BUSY_IF;
          starve_cnt_d = '0;
        end
      end

      S_BUSY_IF, S_BUSY_DM: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (done_ok || done_to) begin
          mem_req_d = 1'b0;
          err_d     = done_to;
          state_d   = S_RESP;
          if (state_q == S_BUSY_IF) begin
            if_rdata_d = resp_data;
            if_ack_d   = 1'b1;
          end else begin
            // A store returns nothing, so the last load value is kept.
            if (!mem_we_q) begin
              dm_rdata_d = resp_data;
            end
            dm_ack_d = 1'b1;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      starve_cnt_q <= '0;
      to_cnt_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      if_ack_q     <= 1'b0;
      dm_rdata_q   <= '0;
      dm_ack_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      to_cnt_q     <= to_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      if_ack_q     <= if_ack_d;
      dm_rdata_q   <= dm_rdata_d;
      dm_ack_q     <= dm_ack_d;
      err_q        <= err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_ack_o    = dm_ack_q;
  assign err_o       = err_q;

  // A requester stays stalled until the cycle its ack is visible.
  assign stall_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with a small behavioural memory that acks
// after a programmable number of wait cycles. Inputs are driven and outputs
// sampled on the falling clock edge. A monitor logs the address of every new
// memory request so grant order can be checked.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk_i;
  logic              rst_i;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_ack_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;
  logic              err_o;
  logic              stall_o;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4), .TIMEOUT(64)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .err_o(err_o), .stall_o(stall_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  logic [31:0] tb_mem [0:255];
  bit          mem_en;
  int          lat;
  int          wait_cnt;
  logic [31:0] grant_log [$];
  logic        prev_req;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("  ok   %s = %h", tag, got);
    end
  endtask

  // Waits on falling edges for the selected ack; n = falling edges consumed.
  task automatic wait_ack(input bit is_dm, input string tag, output int n);
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk_i);
      n++;
      seen = is_dm ? dm_ack_o : if_ack_o;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  // Behavioural memory: acks after lat wait cycles of a raised request.
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    wait_cnt    = 0;
    forever begin
      @(negedge clk_i);
      if (mem_en) begin
        if (mem_ack_i) begin
          mem_ack_i   = 1'b0;
          mem_rdata_i = '0;
          wait_cnt    = 0;
        end else if (mem_req_o) begin
          if (wait_cnt >= lat) begin
            mem_ack_i = 1'b1;
            if (mem_we_o) begin
              tb_mem[mem_addr_o[9:2]] = mem_wdata_o;
              mem_rdata_i = '0;
            end else begin
              mem_rdata_i = tb_mem[mem_addr_o[9:2]];
            end
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  // Grant monitor: one log entry per rising edge of mem_req_o.
  initial begin
    prev_req = 1'b0;
    forever begin
      @(negedge clk_i);
      if (mem_req_o === 1'b1 && prev_req !== 1'b1) grant_log.push_back(mem_addr_o);
      prev_req = mem_req_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] exp_order [7];

    rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_en = 1'b1; lat = 0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'h1000_0000 + 32'(i);
    tb_mem[4]  = 32'hDEADBEEF;   // 0x10
    tb_mem[8]  = 32'hCAFE0001;   // 0x20
    tb_mem[16] = 32'h12345678;   // 0x40

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    chk("rst_acks_err", {29'd0, if_ack_o, dm_ack_o, err_o}, 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_dm_rdata", dm_rdata_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    rst_i = 1'b0;

    // T1: IF read of 0x10, memory acks 2 cycles after the request rises
    lat = 2; if_addr_i = 32'h10; if_req_i = 1'b1;
    @(negedge clk_i);
    chk("t1_mem_req", 32'(mem_req_o), 32'd1);
    chk("t1_mem_addr", mem_addr_o, 32'h10);
    chk("t1_mem_we", 32'(mem_we_o), 32'd0);
    chk("t1_stall_busy", 32'(stall_o), 32'd1);
    wait_ack(1'b0, "t1_if_ack", n);
    chk("t1_latency", 32'(n + 1), 32'd4);
    chk("t1_if_rdata", if_rdata_o, 32'hDEADBEEF);
    chk("t1_stall_ack", 32'(stall_o), 32'd0);
    chk("t1_err", 32'(err_o), 32'd0);
    if_req_i = 1'b0;
    @(negedge clk_i);
    chk("t1_ack_pulse", 32'(if_ack_o), 32'd0);
    chk("t1_stall_after", 32'(stall_o), 32'd0);

    // T1b: minimum latency, memory acks in the first BUSY cycle
    lat = 0; if_addr_i = 32'h20; if_req_i = 1'b1;
    wait_ack(1'b0, "t1b_if_ack", n);
    chk("t1b_latency", 32'(n), 32'd2);
    chk("t1b_if_rdata", if_rdata_o, 32'hCAFE0001);
    if_req_i = 1'b0;
    @(negedge clk_i);

    // T2: simultaneous IF and DM load, DM first
    grant_log.delete();
    lat = 1; if_addr_i = 32'h20; dm_addr_i = 32'h40; dm_we_i = 1'b0;
    if_req_i = 1'b1; dm_req_i = 1'b1;
    @(negedge clk_i);
    chk("t2_first_addr", mem_addr_o, 32'h40);
    wait_ack(1'b1, "t2_dm_ack", n);
    chk("t2_dm_rdata", dm_rdata_o, 32'h12345678);
    chk("t2_if_ack_low", 32'(if_ack_o), 32'd0);
    dm_req_i = 1'b0;
    wait_ack(1'b0, "t2_if_ack", n);
    chk("t2_if_rdata", if_rdata_o, 32'hCAFE0001);
    if_req_i = 1'b0;
    chk("t2_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("t2_grant0", grant_log[0], 32'h40);
      chk("t2_grant1", grant_log[1], 32'h20);
    end
    @(negedge clk_i);

    // T3: five back-to-back stores with IF held -> DM,DM,DM,DM,IF,DM,(IF)
    grant_log.delete();
    lat = 0; if_addr_i = 32'h100; if_req_i = 1'b1; dm_we_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dm_addr_i  = 32'h200 + 32'(4 * i);
      dm_wdata_i = 32'hA0 + 32'(i);
      dm_req_i   = 1'b1;
      wait_ack(1'b1, "t3_dm_ack", n);
    end
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    wait_ack(1'b0, "t3_if_ack", n);
    if_req_i = 1'b0;
    @(negedge clk_i);
    exp_order = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h100, 32'h210, 32'h100};
    chk("t3_grants", 32'(grant_log.size()), 32'd7);
    if (grant_log.size() == 7) begin
      for (int i = 0; i < 7; i++) chk($sformatf("t3_grant%0d", i), grant_log[i], exp_order[i]);
    end

    // T4: DM store 0x55AA to 0x80
    lat = 1; dm_we_i = 1'b1; dm_addr_i = 32'h80; dm_wdata_i = 32'h55AA; dm_req_i = 1'b1;
    @(negedge clk_i);
    chk("t4_mem_we", 32'(mem_we_o), 32'd1);
    chk("t4_mem_wdata", mem_wdata_o, 32'h55AA);
    chk("t4_mem_addr", mem_addr_o, 32'h80);
    wait_ack(1'b1, "t4_dm_ack", n);
    chk("t4_dm_rdata_kept", dm_rdata_o, 32'h12345678);
    chk("t4_err", 32'(err_o), 32'd0);
    chk("t4_mem_written", tb_mem[32], 32'h55AA);
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    @(negedge clk_i);
    chk("t4_ack_pulse", 32'(dm_ack_o), 32'd0);

    // T5: memory never acks -> abort 64 cycles after grant
    mem_en = 1'b0; dm_addr_i = 32'h44; dm_we_i = 1'b0; dm_req_i = 1'b1;
    wait_ack(1'b1, "t5_dm_ack", n);
    chk("t5_latency", 32'(n), 32'd65);
    chk("t5_err", 32'(err_o), 32'd1);
    chk("t5_dm_rdata", dm_rdata_o, 32'd0);
    dm_req_i = 1'b0;
    @(negedge clk_i);
    chk("t5_err_pulse", 32'(err_o), 32'd0);
    chk("t5_mem_req", 32'(mem_req_o), 32'd0);
    mem_en = 1'b1; lat = 0; dm_addr_i = 32'h40; dm_req_i = 1'b1;
    wait_ack(1'b1, "t5_recover_ack", n);
    chk("t5_recover_lat", 32'(n), 32'd2);
    chk("t5_recover_data", dm_rdata_o, 32'h12345678);
    dm_req_i = 1'b0;
    @(negedge clk_i);

    // T6: reset in the 2nd BUSY_DM cycle, then a spurious ack
    mem_en = 1'b0; dm_addr_i = 32'h48; dm_we_i = 1'b0; dm_req_i = 1'b1;
    @(negedge clk_i);
    chk("t6_busy_req", 32'(mem_req_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("t6_mem_req", 32'(mem_req_o), 32'd0);
    chk("t6_no_ack", {30'd0, dm_ack_o, err_o}, 32'd0);
    chk("t6_dm_rdata", dm_rdata_o, 32'd0);
    dm_req_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t6_spurious", {29'd0, dm_ack_o, if_ack_o, mem_req_o}, 32'd0);
    end
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    grant_log.delete();
    mem_en = 1'b1; lat = 0; if_addr_i = 32'h10; if_req_i = 1'b1;
    wait_ack(1'b0, "t6_fresh_ack", n);
    chk("t6_fresh_lat", 32'(n), 32'd2);
    chk("t6_fresh_data", if_rdata_o, 32'hDEADBEEF);
    if_req_i = 1'b0;
    @(negedge clk_i);
    chk("t6_fresh_grants", 32'(grant_log.size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
